switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer_pkg.sv | 30 +++
 rtl/switch_debouncer_channel.sv | 90 +++++++++
 rtl/switch_debouncer.sv | 44 ++++
 tb/tb_switch_debouncer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch debouncer and its consumers.
// The bit-index constants fix which o_sw bit feeds which blinker input.
package switch_debouncer_pkg;

  localparam int unsigned NUM_SW_DEFAULT          = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250;
  localparam int unsigned CNT_W_DEFAULT           = 14;

  // Bit mapping of the switch vector at top level
  localparam int unsigned SW_ENABLE = 0;
  localparam int unsigned SW_S2     = 1;
  localparam int unsigned SW_S1     = 2;

  // What the filter does with a channel on a given edge
  typedef enum logic [1:0] {
    FILT_HOLD   = 2'd0,  // synchronised level matches output: clear counter
    FILT_COUNT  = 2'd1,  // level differs, still waiting: advance counter
    FILT_ACCEPT = 2'd2   // level differed long enough: take it and strobe
  } filt_action_e;

  // True when the stability count fits in a CNT_W-bit counter
  function automatic bit debounce_cfg_ok(input int unsigned cycles,
                                         input int unsigned width);
    longint unsigned max_cnt;
    if (width < 1 || width > 31) return 1'b0;
    max_cnt = (64'd1 << width) - 64'd1;
    return (cycles >= 1) && (longint'(cycles) <= max_cnt);
  endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One debounced switch channel: two-flop synchroniser, stability counter,
// registered level and one-cycle rise/fall strobes.
//
// filter action | meaning
// FILT_HOLD     | sync level equals accepted level, counter cleared
// FILT_COUNT    | sync level differs, counter below terminal count
// FILT_ACCEPT   | sync level differs at terminal count, level taken, strobe
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic i_clck,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);

  // Counter value on the edge that accepts a new level
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  filt_action_e     action;

  // Two-flop synchroniser; sync2_q is the only signal the filter looks at
  always_ff @(posedge i_clck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  // Decide hold / count / accept and form the next filter state
  always_comb begin
    action  = FILT_HOLD;
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (sync2_q != level_q) begin
      action = (cnt_q == CNT_TC) ? FILT_ACCEPT : FILT_COUNT;
    end

    case (action)
      FILT_COUNT: begin
        cnt_d = cnt_q + 1'b1;
      end
      FILT_ACCEPT: begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Filter state register; reset discards any partial count
  always_ff @(posedge i_clck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_sw   = level_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW raw switch inputs into clean levels and edge strobes
// for the LED blinker (bit mapping in switch_debouncer_pkg).
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned NUM_SW          = NUM_SW_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic              i_clck,
  input  logic              i_rst_n,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_sw,
  output logic [NUM_SW-1:0] o_rise,
  output logic [NUM_SW-1:0] o_fall
);

  // A count that does not fit the counter could never be reached
  if (!debounce_cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
    $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be 1..2^CNT_W-1");
  end

  if (NUM_SW < 1) begin : g_bad_width
    $fatal(1, "switch_debouncer: NUM_SW must be at least 1");
  end

  // Channels are fully independent; each may strobe on the same edge
  for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .i_clck (i_clck),
      .i_rst_n(i_rst_n),
      .i_sw   (i_sw[n]),
      .o_sw   (o_sw[n]),
      .o_rise (o_rise[n]),
      .o_fall (o_fall[n])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, CNT_W=4.
// A level change applied just after an edge is accepted on the 6th edge.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic [2:0] o_sw, o_rise, o_fall;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(
    .NUM_SW(3), .DEBOUNCE_CYCLES(4), .CNT_W(4), .RESET_LEVEL(1'b0)
  ) dut (
    .i_clck (clk),
    .i_rst_n(rst_n),
    .i_sw   (sw),
    .o_sw   (o_sw),
    .o_rise (o_rise),
    .o_fall (o_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_sw,
                         input logic [2:0] e_rise, input logic [2:0] e_fall);
    chk({tag, ".o_sw"},   o_sw,   e_sw);
    chk({tag, ".o_rise"}, o_rise, e_rise);
    chk({tag, ".o_fall"}, o_fall, e_fall);
  endtask

  initial begin
    // Reset held with all inputs high
    rst_n = 1'b0;
    sw    = 3'b111;
    #1;
    chk_all("rst_t0", 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst_hold", 3'b000, 3'b000, 3'b000);
    end
    rst_n = 1'b1;
    tick();
    chk_all("rst_first_edge", 3'b000, 3'b000, 3'b000);

    // Return to a quiet all-low state
    rst_n = 1'b0;
    sw    = 3'b000;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_all("quiet", 3'b000, 3'b000, 3'b000);

    // Clean rise on enable (bit 0)
    sw[SW_ENABLE] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("rise_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("rise_edge6", 3'b001, 3'b001, 3'b000);
    tick();
    chk_all("rise_edge7", 3'b001, 3'b000, 3'b000);

    // Bounce on s2 (bit 1): 1,0,1,0 for two cycles each, then settle high
    for (int b = 0; b < 4; b++) begin
      sw[SW_S2] = (b % 2 == 0);
      for (int i = 0; i < 2; i++) begin
        tick();
        chk_all("bounce", 3'b001, 3'b000, 3'b000);
      end
    end
    sw[SW_S2] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("bounce_settle", 3'b001, 3'b000, 3'b000);
    end
    tick();
    chk_all("bounce_accept", 3'b011, 3'b010, 3'b000);
    tick();
    chk_all("bounce_after", 3'b011, 3'b000, 3'b000);

    // Three-cycle low pulse on enable is one short of acceptance
    sw[SW_ENABLE] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    sw[SW_ENABLE] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("short_pulse", 3'b011, 3'b000, 3'b000);
    end

    // Raise s1 (bit 2), then a clean fall on it
    sw[SW_S1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_all("s1_pre", 3'b011, 3'b000, 3'b000);
    tick();
    chk_all("s1_rise", 3'b111, 3'b100, 3'b000);
    tick();
    sw[SW_S1] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("fall_wait", 3'b111, 3'b000, 3'b000);
    end
    tick();
    chk_all("fall_edge6", 3'b011, 3'b000, 3'b100);
    tick();
    chk_all("fall_edge7", 3'b011, 3'b000, 3'b000);

    // Drop the rest, then all three rise together
    sw = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    chk_all("all_fall_pre", 3'b011, 3'b000, 3'b000);
    tick();
    chk_all("all_fall", 3'b000, 3'b000, 3'b011);
    tick();
    sw = 3'b111;
    for (int i = 0; i < 5; i++) tick();
    chk_all("simul_pre", 3'b000, 3'b000, 3'b000);
    tick();
    chk_all("simul_rise", 3'b111, 3'b111, 3'b000);
    tick();
    chk_all("simul_after", 3'b111, 3'b000, 3'b000);

    // Reset in the middle of a fall count: output snaps to reset level
    sw = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    chk_all("midcnt_pre", 3'b111, 3'b000, 3'b000);
    rst_n = 1'b0;
    #1;
    chk_all("midcnt_async", 3'b000, 3'b000, 3'b000);
    sw = 3'b111;
    tick();
    chk_all("midcnt_hold", 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("post_rst_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("post_rst_accept", 3'b111, 3'b111, 3'b000);
    tick();
    chk_all("post_rst_after", 3'b111, 3'b000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
